// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and the write-back queue entry layout.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: in-order circular buffer of long-latency results with squash-by-rd
// and two pending-write lookups.
module wb_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  i_push,
  input  logic                  i_valid,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [XLEN-1:0]       i_data,
  input  logic                  i_pop,
  input  logic                  i_squash,
  input  logic [REG_ADDR_W-1:0] i_squash_rd,
  input  logic [REG_ADDR_W-1:0] i_qa,
  input  logic [REG_ADDR_W-1:0] i_qb,
  output logic                  o_head_valid,
  output logic [REG_ADDR_W-1:0] o_head_rd,
  output logic [XLEN-1:0]       o_head_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_hit_a,
  output logic                  o_hit_b
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  wb_entry       r_q [DEPTH];
  logic          w_push, w_pop;
  assign o_empty = r_count == '0;
  assign o_full  = r_count == (PW+1)'(DEPTH);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head_valid = r_q[r_head].valid;
  assign o_head_rd    = r_q[r_head].rd;
  assign o_head_data  = r_q[r_head].data;
  // Free slots keep valid=0, so lookups may scan every slot without masking.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_squash && r_q[i].rd == i_squash_rd) r_q[i].valid <= 1'b0;
      if (w_pop) begin
        r_q[r_head].valid <= 1'b0;
        r_head <= r_head + 1'b1;
      end
      if (w_push) begin
        r_q[r_tail] <= '{valid: i_valid, rd: i_rd, data: i_data};
        r_tail <= r_tail + 1'b1;
      end
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  always_comb begin
    o_hit_a = 1'b0;
    o_hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit_a = o_hit_a | (r_q[i].valid && r_q[i].rd == i_qa);
      o_hit_b = o_hit_b | (r_q[i].valid && r_q[i].rd == i_qb);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write port shared by the ALU (priority) and the
// queued long-latency path, plus pending-write hazard reporting.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int width     = XLEN,
  parameter int addrWidth = REG_ADDR_W,
  parameter int DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 aluValid,
  input  logic [addrWidth-1:0] aluRd,
  input  logic [width-1:0]     aluData,
  input  logic                 memValid,
  output logic                 memReady,
  input  logic [addrWidth-1:0] memRd,
  input  logic [width-1:0]     memData,
  output logic                 regWriteEnable,
  output logic [addrWidth-1:0] addrD,
  output logic [width-1:0]     dataD,
  input  logic [addrWidth-1:0] qAddrA,
  input  logic [addrWidth-1:0] qAddrB,
  output logic                 busyA,
  output logic                 busyB
);
  logic                 r_we;
  logic [addrWidth-1:0] r_addr;
  logic [width-1:0]     r_data;
  logic                 w_alu, w_pop, w_empty, w_full, w_hit_a, w_hit_b;
  logic                 w_head_valid;
  logic [addrWidth-1:0] w_head_rd;
  logic [width-1:0]     w_head_data;
  assign w_alu    = aluValid && aluRd != '0;
  assign w_pop    = !w_alu && !w_empty;
  assign memReady = !w_full;
  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clock       (clock),
    .clear       (clear),
    .i_push      (memValid && memReady && memRd != '0),
    .i_valid     (!(w_alu && aluRd == memRd)),
    .i_rd        (memRd),
    .i_data      (memData),
    .i_pop       (w_pop),
    .i_squash    (w_alu),
    .i_squash_rd (aluRd),
    .i_qa        (qAddrA),
    .i_qb        (qAddrB),
    .o_head_valid(w_head_valid),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_hit_a     (w_hit_a),
    .o_hit_b     (w_hit_b)
  );
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_alu || (w_pop && w_head_valid);
      if (w_alu) begin
        r_addr <= aluRd;
        r_data <= aluData;
      end else if (w_pop && w_head_valid) begin
        r_addr <= w_head_rd;
        r_data <= w_head_data;
      end
    end
  end
  assign regWriteEnable = r_we;
  assign addrD = r_addr;
  assign dataD = r_data;
  assign busyA = qAddrA != '0 && (w_hit_a || (r_we && r_addr == qAddrA));
  assign busyB = qAddrB != '0 && (w_hit_b || (r_we && r_addr == qAddrB));
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-side driver for the CPU's integer register file: owns the single write port (regWriteEnable / addrD / dataD).
- Merges two result producers: the single-cycle ALU, which is never stalled, and the long-latency load/multiply path, which uses a valid/ready handshake and is buffered in a small in-order queue.
- Also reports pending-write hazards for two read addresses so issue logic can stall reads of registers not yet written.

Parameters:
width, 32, data width of results and register file
addrWidth, 5, register address width
DEPTH, 4, queue entries for long-latency results (power of two, >=2)

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-low reset
aluValid  input  1  ALU result valid this cycle (always accepted)
aluRd  input  addrWidth  ALU destination register
aluData  input  width  ALU result
memValid  input  1  long-latency result offered
memReady  output  1  queue can accept (count != DEPTH)
memRd  input  addrWidth  long-latency destination
memData  input  width  long-latency result
regWriteEnable  output  1  register file write enable (registered)
addrD  output  addrWidth  register file write address (registered)
dataD  output  width  register file write data (registered)
qAddrA  input  addrWidth  hazard query address A
qAddrB  input  addrWidth  hazard query address B
busyA  output  1  write to qAddrA pending
busyB  output  1  write to qAddrB pending

Behaviour:
- Reset (clear low, asynchronous): regWriteEnable=0, addrD=0, dataD=0; queue empty, all entry valid bits 0, count=0. memReady is combinational from count, so it is 1 once reset is applied. Reset mid-operation discards all pending results.
- Memory push: when memValid && memReady, the entry {rd, data} is enqueued at the tail with valid=1. memRd==0 is accepted but not enqueued; count is unchanged.
- memReady = (count != DEPTH) from registered count only. A pop in the same cycle does not raise memReady; there is no combinational path from pop to ready.
- Write-port selection, evaluated each cycle and registered at posedge:
  - If aluValid && aluRd!=0: drive ALU result; regWriteEnable=1 next cycle; no queue pop.
  - Else if queue head exists: pop head; if head valid, drive it with regWriteEnable=1; if head squashed, regWriteEnable=0.
  - Else regWriteEnable=0; addrD/dataD hold previous values.
- Latency: ALU result appears on the write port 1 cycle after aluValid. A memory result reaches the port at earliest 2 cycles after acceptance (push cycle, then pop cycle).
- ALU has strict priority. Sustained ALU traffic may starve the queue; memReady then drops when the queue is full.
- Ordering (last writer wins): an ALU result is younger than every queued entry.
  - On aluValid && aluRd!=0, every queued entry with rd==aluRd has its valid bit cleared (squashed). Squashed entries still occupy slots until popped.
  - Simultaneous ALU and memory push with the same rd: the memory entry is enqueued already squashed.
- Simultaneous push and pop: count is unchanged; pointers both advance modulo DEPTH.
- Hazard: busyX=1 iff qAddrX!=0 and (any valid queue entry has rd==qAddrX, or regWriteEnable && addrD==qAddrX). Purely combinational from state. x0 is never busy.
- aluRd==0 is ignored entirely: no write, no squash.

Decomposition:
- Shared package riscv_pkg: XLEN=32, REG_ADDR_W=5, a wb_entry typedef {valid, rd, data}.
- One sub-module wb_queue: circular buffer with push, pop, head read, per-entry squash-by-rd, and a match-by-rd hit output used twice for busyA/busyB.
- wb_arbiter holds the priority mux and the output registers.

Test Plan:
- Reset then aluValid=1, aluRd=5, aluData=0xDEADBEEF for 1 cycle -> next cycle regWriteEnable=1, addrD=5, dataD=0xDEADBEEF; following cycle regWriteEnable=0.
- Push mem rd=3 data=0x11 with no ALU -> write port shows addrD=3, dataD=0x11 two cycles after acceptance; busyA=1 with qAddrA=3 until that write cycle ends.
- ALU active every cycle while pushing 5 mem results (rd 1..5) -> memReady drops to 0 after 4 accepts; after ALU stops, writes drain in order rd 1,2,3,4 then 5.
- Queue holds rd=7 data=0xAA, then ALU writes rd=7 data=0xBB -> one write of 0xBB to rd 7; squashed entry later pops with regWriteEnable=0; busy for rd 7 clears after the ALU write.
- memRd=0 and aluRd=0 offered -> memReady stays 1, count unchanged, regWriteEnable never asserts; qAddrA=0 gives busyA=0.
- Assert clear low with 3 queued entries mid-drain -> all outputs 0 immediately (asynchronously), memReady=1, and no stale writes after clear returns high.
